// File: rtl/seg_scan_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_decoder_if
//  Description : Bundle of the scanned seven-segment bus (select + segments)
//                and the decoded frame outputs of seg_scan_decoder.
//  Revision    : 1.0  initial release
// ============================================================================
interface seg_scan_decoder_if;
    logic [7:0]  digit_scan;    // active-low one-hot digit select
    logic [7:0]  digit_cath;    // active-high segments, bit7 = dp
    logic [31:0] digit_val;     // decoded nibble per digit
    logic [7:0]  digit_dp;
    logic [7:0]  digit_ok;
    logic        frame_valid;
    logic        frame_strobe;
    logic        scan_err;
    logic [7:0]  err_cnt;

    // Display side: drives the scan bus, observes the decoded frame
    modport master (
        output digit_scan, digit_cath,
        input  digit_val, digit_dp, digit_ok, frame_valid, frame_strobe,
               scan_err, err_cnt
    );

    // Decoder side
    modport slave (
        input  digit_scan, digit_cath,
        output digit_val, digit_dp, digit_ok, frame_valid, frame_strobe,
               scan_err, err_cnt
    );
endinterface
`default_nettype wire

// File: rtl/seg_scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_decoder
//  Description : Samples a multiplexed 8-digit seven-segment scan bus,
//                debounces each scan slot, decodes segment patterns to hex
//                and assembles complete frames; flags illegal scan words and
//                a stalled scanner.
//  Revision    : 1.0  initial release
// ============================================================================
module seg_scan_decoder #(
    parameter int SETTLE      = 4,
    parameter int STALE_LIMIT = 65535
) (
    input  logic               clk,
    input  logic               rst_n,
    seg_scan_decoder_if.slave  bus
);

    localparam logic [7:0]  c_settle       = 8'(SETTLE);
    localparam logic [7:0]  c_settle_m1    = 8'(SETTLE - 1);
    localparam logic [19:0] c_stale_limit  = 20'(STALE_LIMIT);
    localparam logic [19:0] c_stale_lim_m1 = 20'(STALE_LIMIT - 1);

    logic [7:0]  r_s1_scan, r_s2_scan, r_s1_cath, r_s2_cath;
    logic [7:0]  r_hold_scan, r_hold_cath;
    logic [7:0]  r_stab_cnt;
    logic [7:0]  r_seen;
    logic [19:0] r_timer;
    logic [31:0] r_val;
    logic [7:0]  r_dp, r_ok;
    logic        r_frame_valid, r_frame_strobe, r_scan_err;
    logic [7:0]  r_err_cnt;

    logic        w_stable, w_capture, w_onehot, w_blank;
    logic        w_legal, w_illegal, w_complete, w_expire;
    logic [7:0]  w_sel, w_seen_next;
    logic [3:0]  w_dec_val;
    logic        w_dec_ok;

    // Two-flop synchronizers; idle bus is "no digit selected, all segments off"
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_scan <= 8'hFF;
            r_s2_scan <= 8'hFF;
            r_s1_cath <= 8'h00;
            r_s2_cath <= 8'h00;
        end else begin
            r_s1_scan <= bus.digit_scan;
            r_s2_scan <= r_s1_scan;
            r_s1_cath <= bus.digit_cath;
            r_s2_cath <= r_s1_cath;
        end
    end

    // Stability counter: restarts on any change, saturates at SETTLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_scan <= 8'hFF;
            r_hold_cath <= 8'h00;
            r_stab_cnt  <= 8'd0;
        end else begin
            r_hold_scan <= r_s2_scan;
            r_hold_cath <= r_s2_cath;
            if (!w_stable)
                r_stab_cnt <= 8'd0;
            else if (r_stab_cnt != c_settle)
                r_stab_cnt <= r_stab_cnt + 8'd1;
        end
    end

    // Capture qualification: one pulse per stable period, classified by select
    always_comb begin
        w_stable    = (r_s2_scan == r_hold_scan) && (r_s2_cath == r_hold_cath);
        w_capture   = w_stable && (r_stab_cnt == c_settle_m1);
        w_sel       = ~r_s2_scan;
        w_onehot    = (w_sel != 8'd0) && ((w_sel & (w_sel - 8'd1)) == 8'd0);
        w_blank     = (r_s2_scan == 8'hFF);
        w_legal     = w_capture && w_onehot;
        w_illegal   = w_capture && !w_onehot && !w_blank;
        w_seen_next = r_seen | w_sel;
        w_complete  = w_legal && (w_seen_next == 8'hFF);
        // A legal capture restarts the timer, so it always beats expiry
        w_expire    = !w_legal && (r_timer == c_stale_lim_m1);
    end

    // Segment pattern to hex lookup; unknown patterns decode as 0 / not ok
    always_comb begin
        w_dec_val = 4'h0;
        w_dec_ok  = 1'b1;
        case (r_s2_cath[6:0])
            7'h3F: w_dec_val = 4'h0;
            7'h06: w_dec_val = 4'h1;
            7'h5B: w_dec_val = 4'h2;
            7'h4F: w_dec_val = 4'h3;
            7'h66: w_dec_val = 4'h4;
            7'h6D: w_dec_val = 4'h5;
            7'h7D: w_dec_val = 4'h6;
            7'h07: w_dec_val = 4'h7;
            7'h7F: w_dec_val = 4'h8;
            7'h6F: w_dec_val = 4'h9;
            7'h77: w_dec_val = 4'hA;
            7'h7C: w_dec_val = 4'hB;
            7'h39: w_dec_val = 4'hC;
            7'h5E: w_dec_val = 4'hD;
            7'h79: w_dec_val = 4'hE;
            7'h71: w_dec_val = 4'hF;
            default: begin
                w_dec_val = 4'h0;
                w_dec_ok  = 1'b0;
            end
        endcase
    end

    // Per-digit value/dp/ok registers, written only by a legal capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_val <= 32'd0;
            r_dp  <= 8'd0;
            r_ok  <= 8'd0;
        end else if (w_legal) begin
            for (int i = 0; i < 8; i++) begin
                if (w_sel[i]) begin
                    r_val[4*i +: 4] <= w_dec_val;
                    r_dp[i]         <= r_s2_cath[7];
                    r_ok[i]         <= w_dec_ok;
                end
            end
        end
    end

    // Frame assembly and stale handling
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seen         <= 8'd0;
            r_frame_valid  <= 1'b0;
            r_frame_strobe <= 1'b0;
        end else begin
            r_frame_strobe <= w_complete;
            if (w_legal) begin
                if (w_complete) begin
                    r_seen        <= 8'd0;
                    r_frame_valid <= 1'b1;
                end else begin
                    r_seen <= w_seen_next;
                end
            end else if (w_expire) begin
                r_seen        <= 8'd0;
                r_frame_valid <= 1'b0;
            end
        end
    end

    // Stale timer: clocks since the last legal capture, held at the limit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_timer <= 20'd0;
        else if (w_legal)
            r_timer <= 20'd0;
        else if (r_timer != c_stale_limit)
            r_timer <= r_timer + 20'd1;
    end

    // Illegal scan word pulse and saturating counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan_err <= 1'b0;
            r_err_cnt  <= 8'd0;
        end else begin
            r_scan_err <= w_illegal;
            if (w_illegal && (r_err_cnt != 8'hFF))
                r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign bus.digit_val    = r_val;
    assign bus.digit_dp     = r_dp;
    assign bus.digit_ok     = r_ok;
    assign bus.frame_valid  = r_frame_valid;
    assign bus.frame_strobe = r_frame_strobe;
    assign bus.scan_err     = r_scan_err;
    assign bus.err_cnt      = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg_scan_decoder
//  Description : Scoreboard bench for seg_scan_decoder: directed scan vectors,
//                expected strobe/error events queued, monitor pops on events.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seg_scan_decoder;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seg_scan_decoder_if bus();

    seg_scan_decoder #(.SETTLE(4), .STALE_LIMIT(100)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        bit          is_strobe;
        logic [31:0] val;
        logic [7:0]  dp;
        logic [7:0]  ok;
        logic [7:0]  ec;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   strobe_cyc = 0;
    int   n_strobe   = 0;

    logic [7:0] pat [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                             8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Set inputs at a falling edge and hold them for n rising edges
    task automatic drive(input logic [7:0] s, input logic [7:0] c, input int n);
        bus.digit_scan = s;
        bus.digit_cath = c;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_val"},    bus.digit_val, 32'h0);
        check({tag, "_dp"},     {24'h0, bus.digit_dp}, 32'h0);
        check({tag, "_ok"},     {24'h0, bus.digit_ok}, 32'h0);
        check({tag, "_fvalid"}, {31'h0, bus.frame_valid}, 32'h0);
        check({tag, "_strobe"}, {31'h0, bus.frame_strobe}, 32'h0);
        check({tag, "_err"},    {31'h0, bus.scan_err}, 32'h0);
        check({tag, "_errcnt"}, {24'h0, bus.err_cnt}, 32'h0);
    endtask

    task automatic scan_frame();
        logic [7:0] sel;
        for (int d = 0; d < 8; d++) begin
            sel = 8'h01 << d;
            sel = ~sel;
            drive(sel, pat[d] | ((d == 3) ? 8'h80 : 8'h00), 50);
        end
    endtask

    // Monitor: pops one expected event per strobe / error pulse
    always @(negedge clk) begin
        if (rst_n && (bus.frame_strobe || bus.scan_err)) begin
            check("strobe_err_exclusive", {31'h0, bus.frame_strobe & bus.scan_err}, 32'h0);
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_event: strobe=%0b err=%0b with empty queue",
                         bus.frame_strobe, bus.scan_err);
            end else begin
                mon_e = q.pop_front();
                check("event_kind", {31'h0, bus.frame_strobe}, {31'h0, mon_e.is_strobe});
                check("event_val", bus.digit_val, mon_e.val);
                if (mon_e.is_strobe) begin
                    check("event_dp", {24'h0, bus.digit_dp}, {24'h0, mon_e.dp});
                    check("event_ok", {24'h0, bus.digit_ok}, {24'h0, mon_e.ok});
                    check("event_fvalid", {31'h0, bus.frame_valid}, 32'h1);
                    strobe_cyc = cyc;
                    n_strobe++;
                end else begin
                    check("event_errcnt", {24'h0, bus.err_cnt}, {24'h0, mon_e.ec});
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        bus.digit_scan = 8'hFF;
        bus.digit_cath = 8'h00;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        drive(8'hFF, 8'h00, 20);
        check("idle_fvalid", {31'h0, bus.frame_valid}, 32'h0);

        // Full frame 0..7, dp on digit 3
        q.push_back('{1'b1, 32'h76543210, 8'h08, 8'hFF, 8'h00});
        scan_frame();
        check("frame1_strobes", n_strobe, 1);
        check("frame1_val", bus.digit_val, 32'h76543210);
        check("frame1_dp", {24'h0, bus.digit_dp}, 32'h08);
        check("frame1_ok", {24'h0, bus.digit_ok}, 32'hFF);
        check("frame1_fvalid", {31'h0, bus.frame_valid}, 32'h1);

        // Glitch on digit 2: 3 clocks ignored, 5 clocks captured
        drive(~8'h04, 8'h5B, 50);
        drive(~8'h04, 8'h06, 3);
        drive(~8'h04, 8'h5B, 20);
        check("glitch3_d2", {28'h0, bus.digit_val[11:8]}, 32'h2);
        drive(~8'h04, 8'h06, 5);
        drive(~8'h04, 8'h5B, 2);
        check("glitch5_d2", {28'h0, bus.digit_val[11:8]}, 32'h1);
        drive(~8'h04, 8'h5B, 30);
        check("glitch_restore_d2", {28'h0, bus.digit_val[11:8]}, 32'h2);

        // Unknown pattern on digit 5
        drive(~8'h20, 8'h55, 50);
        check("unknown_d5", {28'h0, bus.digit_val[23:20]}, 32'h0);
        check("unknown_ok", {24'h0, bus.digit_ok}, 32'hDF);
        check("unknown_val", bus.digit_val, 32'h76043210);

        // Illegal scan words, counter saturation
        for (int n = 1; n <= 300; n++) begin
            q.push_back('{1'b0, 32'h76043210, 8'h00, 8'h00, (n > 255) ? 8'hFF : 8'(n)});
            drive(8'hFC, 8'h00, 20);
            if (n == 1)
                check("illegal_first_cnt", {24'h0, bus.err_cnt}, 32'h1);
            drive(8'hFF, 8'h00, 6);
        end
        check("illegal_sat_cnt", {24'h0, bus.err_cnt}, 32'hFF);
        check("illegal_val", bus.digit_val, 32'h76043210);

        // Stale: complete a frame, then blank scan
        n_strobe = 0;
        q.push_back('{1'b1, 32'h76543210, 8'h08, 8'hFF, 8'h00});
        scan_frame();
        check("frame2_strobes", n_strobe, 1);
        check("frame2_fvalid", {31'h0, bus.frame_valid}, 32'h1);
        bus.digit_scan = 8'hFF;
        bus.digit_cath = 8'h00;
        k = 0;
        while (bus.frame_valid && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("stale_timeout_bound", {31'h0, bus.frame_valid}, 32'h0);
        check("stale_delay", cyc - strobe_cyc, 100);
        check("stale_val_kept", bus.digit_val, 32'h76543210);
        check("stale_ok_kept", {24'h0, bus.digit_ok}, 32'hFF);

        // Asynchronous reset mid-run, between clock edges
        drive(~8'h02, 8'h06, 3);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        @(negedge clk);
        bus.digit_scan = 8'hFF;
        bus.digit_cath = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        drive(8'hFF, 8'h00, 30);
        check("post_reset_fvalid", {31'h0, bus.frame_valid}, 32'h0);
        check("post_reset_val", bus.digit_val, 32'h0);
        drive(~8'h02, 8'h06, 7);
        check("post_reset_capture", {28'h0, bus.digit_val[7:4]}, 32'h1);
        drive(~8'h02, 8'h06, 10);

        check("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

Receive-side decoder for the multiplexed 8-digit seven-segment bus (`digit_scan` / `digit_cath`) driven by the selecting-machine display logic. It samples the scanned select and segment lines and debounces each scan slot. It then decodes every segment pattern back to a hex value and assembles a full 8-digit frame, flagging malformed scans and a stalled scanner. It is used as a self-checking monitor on the board and as a scoreboard front-end in simulation.

## Interface
- `SETTLE`, default 4: consecutive clocks the synced inputs must stay unchanged before a slot is captured (legal range 1..255).
- `STALE_LIMIT`, default 65535: clocks without any capture before the frame is declared stale (range 1..2^20-1).

- `clk`  in  1: system clock.
- `rst_n`  in  1: reset; asynchronous, active-low.
- `digit_scan`  in  8: digit select, active-low one-hot; bit i selects digit i.
- `digit_cath`  in  8: segments, active-high; bit7 = dp, bits6..0 = g,f,e,d,c,b,a.
- `digit_val`  out  32: decoded hex values; digit i in bits [4i+3:4i].
- `digit_dp`  out  8: captured dp bit per digit.
- `digit_ok`  out  8: bit i = 1 if digit i's last pattern matched the hex table.
- `frame_valid`  out  1: all 8 digits captured since the last frame start/clear; held until stale or reset.
- `frame_strobe`  out  1: one-clock pulse on frame completion.
- `scan_err`  out  1: one-clock pulse on an illegal scan word.
- `err_cnt`  out  8: saturating count of illegal scan words.

## Operation
- Both inputs pass through a 2-flop synchronizer into s2_scan / s2_cath. The previous s2 values are kept in a hold register.
- The stability counter resets to 0 whenever {s2_scan, s2_cath} differs from the hold register. Otherwise it increments, saturating at SETTLE.
- Capture happens on the single clock where the counter transitions to SETTLE, so there is exactly one capture per stable period.
- Capture classification by s2_scan:
  - Exactly one bit low (index i): write `digit_val[i]`, `digit_dp[i]` and `digit_ok[i]`, and set seen[i].
  - 8'hFF (blank slot): no action, and the stale timer is not reset.
  - Any other value: pulse `scan_err` and increment `err_cnt` (saturate at 255). No digit write.
- Decode table, cath[6:0] to value: 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 6F→9, 77→A, 7C→b, 39→C, 5E→d, 79→E, 71→F.
- Any other pattern, including 00, writes value 0 and sets ok = 0.
- Frame assembly:
  - When seen becomes 8'hFF (including the capture that sets the last bit), pulse `frame_strobe`, set `frame_valid`, and clear seen in the same clock.
  - Recapturing an already-seen digit overwrites the digit value and does not complete the frame.
- Stale timer:
  - Counts clocks since the last legal one-hot capture.
  - On reaching STALE_LIMIT: clear `frame_valid` and seen, hold the timer at the limit, and leave `digit_val`, `digit_dp` and `digit_ok` unchanged.
  - The next legal capture restarts the timer.
- Simultaneous events:
  - A completing capture in the same clock as timer expiry: the capture wins, so `frame_valid` = 1 and the strobe fires.
  - `scan_err` and `frame_strobe` cannot coincide, because only one capture happens per clock.

## Timing
- Reset values (async on `rst_n` low): `digit_val` = 0, `digit_dp` = 0, `digit_ok` = 0, `frame_valid` = 0, `frame_strobe` = 0, `scan_err` = 0, `err_cnt` = 0. Internal state also resets: seen = 0, synchronizers = 8'hFF / 8'h00, counters = 0.
- Capture latency: a change applied before rising edge E and then held steady is reflected in registered outputs after edge E+SETTLE+2.
- `frame_strobe` and `scan_err` are asserted in that same cycle.
- A change held for fewer than SETTLE+1 clocks produces no capture.
- Reset asserted mid-frame discards partial frame progress. After release, capture resumes within SETTLE+3 clocks of stable input.
- All outputs are registered, with no combinational path from inputs.

## Test plan
- Reset: drive `rst_n` = 0 mid-run. All outputs are 0 immediately, with no clock edge required. After release with static inputs, no strobe occurs.
- Full frame: scan digits 0..7 with patterns for 0,1,2,3,4,5,6,7 (dp on digit 3), 50 clocks each, SETTLE = 4. Result: exactly one `frame_strobe`, `digit_val` = 32'h76543210, `digit_dp` = 8'h08, `digit_ok` = 8'hFF, `frame_valid` = 1.
- Glitch: during a steady digit 2 = 5B, flip `digit_cath` to 06 for 3 clocks (SETTLE = 4). `digit_val[11:8]` stays 2 and no capture occurs. Holding 06 for 5 clocks updates it to 1.
- Illegal scan: drive `digit_scan` = 8'hFC for 20 clocks. Result: one `scan_err` pulse, `err_cnt` = 1, no digit change. Repeat 300 times and `err_cnt` saturates at 255.
- Unknown pattern: digit 5 with `digit_cath` = 0x55. Result: `digit_val[23:20]` = 0 and `digit_ok[5]` = 0.
- Stale: with STALE_LIMIT = 100, complete a frame, then hold the scan at 8'hFF. `frame_valid` drops exactly 100 clocks after the last capture, and `digit_val` keeps its value.
